// File: rtl/slice_config_ctrl.sv
// slice_config_ctrl
// Configuration controller for a daisy-chained set of logic slices.
// It takes bitstream words from the host over a valid/ready stream and drives
// the slices' programming shift chain. It counts words up to the exact chain
// length T. It can optionally verify the load by rotating the chain once
// through its own output while checksumming it. The fabric user registers are
// held in reset until configuration completes.
//
// Ports
//   clk, res          system clock (rising edge), async active-high reset
//   start             one-cycle pulse, starts a load from IDLE/DONE/ERROR
//   verify_en         sampled with start, enables the readback-verify phase
//   abort             level, forces return to IDLE (beats start and accept)
//   cfg_valid/ready   host word handshake, cfg_data is the host word
//   prog_data         word to the first slice's programming input
//   prog_shft         shift strobe to all slices
//   chain_i           programming output of the last slice
//   fabric_nres       active-low reset for the slices' user logic
//   busy/done/err     LOAD or VERIFY / DONE / ERROR status
//   word_cnt          words shifted in the current phase
//
// state  | meaning
// IDLE   | waiting for start, chain contents unknown
// LOAD   | accepting host words, one slice shift per accepted word
// VERIFY | rotating the chain once through chain_i and checksumming it
// DONE   | configuration complete, fabric released from reset
// ERROR  | readback checksum mismatch, fabric held in reset
module slice_config_ctrl #(
  parameter  int DW              = 32,
  parameter  int WORDS_PER_SLICE = 83,
  parameter  int N_SLICES        = 4,
  localparam int T               = N_SLICES * WORDS_PER_SLICE,
  localparam int CW              = $clog2(T + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          verify_en,
  input  logic          abort,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_ready,
  output logic [DW-1:0] prog_data,
  output logic          prog_shft,
  input  logic [DW-1:0] chain_i,
  output logic          fabric_nres,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_cnt
);

  localparam logic [CW-1:0] T_CNT  = CW'(T);
  localparam logic [CW-1:0] T_LAST = CW'(T - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic          verify_q, verify_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [DW-1:0] sum_wr_q, sum_wr_d;
  logic [DW-1:0] sum_rd_q, sum_rd_d;
  logic [DW-1:0] prog_data_q, prog_data_d;
  logic          prog_shft_q, prog_shft_d;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_IDLE;
      verify_q    <= 1'b0;
      word_cnt_q  <= '0;
      sum_wr_q    <= '0;
      sum_rd_q    <= '0;
      prog_data_q <= '0;
      prog_shft_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      verify_q    <= verify_d;
      word_cnt_q  <= word_cnt_d;
      sum_wr_q    <= sum_wr_d;
      sum_rd_q    <= sum_rd_d;
      prog_data_q <= prog_data_d;
      prog_shft_q <= prog_shft_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    verify_d    = verify_q;
    word_cnt_d  = word_cnt_q;
    sum_wr_d    = sum_wr_q;
    sum_rd_d    = sum_rd_q;
    prog_data_d = prog_data_q;
    prog_shft_d = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_d    = S_LOAD;
            verify_d   = verify_en;
            word_cnt_d = '0;
            sum_wr_d   = '0;
            sum_rd_d   = '0;
          end
        end
        S_LOAD: begin
          // Once the count is full this cycle carries the final load shift;
          // leave LOAD only after it so DONE/VERIFY never overlap it.
          if (word_cnt_q == T_CNT) begin
            if (verify_q) begin
              state_d     = S_VERIFY;
              word_cnt_d  = '0;
              prog_shft_d = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else if (cfg_valid) begin
            prog_data_d = cfg_data;
            prog_shft_d = 1'b1;
            word_cnt_d  = word_cnt_q + 1'b1;
            sum_wr_d    = sum_wr_q + cfg_data;
          end
        end
        S_VERIFY: begin
          sum_rd_d   = sum_rd_q + chain_i;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == T_LAST) begin
            state_d = (sum_rd_d == sum_wr_q) ? S_DONE : S_ERROR;
          end else begin
            prog_shft_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // abort gates ready so the host never sees a handshake that is dropped
    cfg_ready   = (state_q == S_LOAD) && (word_cnt_q != T_CNT) && !abort;
    prog_data   = (state_q == S_VERIFY) ? chain_i : prog_data_q;
    prog_shft   = prog_shft_q;
    fabric_nres = (state_q == S_DONE);
    busy        = (state_q == S_LOAD) || (state_q == S_VERIFY);
    done        = (state_q == S_DONE);
    err         = (state_q == S_ERROR);
    word_cnt    = word_cnt_q;
  end

endmodule

// File: tb/tb_slice_config_ctrl.sv
module tb_slice_config_ctrl;

  localparam int T  = 83;
  localparam int CW = 7;

  logic          clk;
  logic          res;
  logic          start;
  logic          verify_en;
  logic          abort;
  logic          cfg_valid;
  logic [31:0]   cfg_data;
  logic          cfg_ready;
  logic [31:0]   prog_data;
  logic          prog_shft;
  logic [31:0]   chain_i;
  logic          fabric_nres;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] word_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int next_word = 1;
  bit stuck_en = 1'b0;
  logic [31:0] exp_q[$];

  slice_config_ctrl #(
    .DW(32),
    .WORDS_PER_SLICE(83),
    .N_SLICES(1)
  ) dut (
    .clk(clk),
    .res(res),
    .start(start),
    .verify_en(verify_en),
    .abort(abort),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .prog_data(prog_data),
    .prog_shft(prog_shft),
    .chain_i(chain_i),
    .fabric_nres(fabric_nres),
    .busy(busy),
    .done(done),
    .err(err),
    .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-slice programming chain; register 0 takes prog_data, register T-1 drives chain_i.
  logic [31:0] chain [T];
  always @(posedge clk) begin
    if (prog_shft) begin
      chain[0] <= prog_data;
      for (int i = 1; i < T; i++) chain[i] <= chain[i-1];
    end
    if (stuck_en) chain[40][0] <= 1'b0;
  end
  assign chain_i = chain[T-1];

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic pulse_start(input bit ve);
    @(negedge clk);
    start = 1'b1;
    verify_en = ve;
    @(negedge clk);
    start = 1'b0;
    verify_en = 1'b0;
  endtask

  // Streams n words from next_word onward, pushing each accepted word to the scoreboard.
  // Starts and ends at a falling edge; ends in the cycle after the last accept.
  task automatic feed(input int n, output bit ok);
    int got;
    got = 0;
    for (int c = 0; c < 4 * n + 10 && got < n; c++) begin
      cfg_valid = 1'b1;
      cfg_data = next_word;
      #1;
      if (cfg_ready) begin
        exp_q.push_back(next_word);
        next_word++;
        got++;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    ok = (got == n);
  endtask

  task automatic test_reset();
    res = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({prog_shft, cfg_ready, fabric_nres, busy, done, err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000000",
               {prog_shft, cfg_ready, fabric_nres, busy, done, err});
    end
    n_cmp++;
    if (prog_data !== 32'd0) begin
      n_err++; $display("FAIL reset_prog_data: got %0d expected 0", prog_data);
    end
    n_cmp++;
    if (word_cnt !== 7'd0) begin
      n_err++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt);
    end
    res = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_ready: got ready=%b busy=%b expected 0 0", cfg_ready, busy);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_load(input bit gapped);
    bit prev_acc, acc;
    int sent, shifts;
    logic [31:0] e;
    exp_q.delete();
    pulse_start(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || word_cnt !== 7'd0 || fabric_nres !== 1'b0) begin
      n_err++;
      $display("FAIL load_entry: got busy=%b cnt=%0d nres=%b expected 1 0 0", busy, word_cnt, fabric_nres);
    end
    prev_acc = 1'b0; sent = 0; shifts = 0;
    for (int cyc = 0; cyc < 400 && !(sent == T && !prev_acc); cyc++) begin
      n_cmp++;
      if (prog_shft !== prev_acc) begin
        n_err++; $display("FAIL load_shft_timing: got %b expected %b (cycle %0d)", prog_shft, prev_acc, cyc);
      end
      if (prog_shft === 1'b1) begin
        shifts++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL load_scoreboard: got shift with data %0d expected no shift", prog_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (prog_data !== e) begin
            n_err++; $display("FAIL load_prog_data: got %0d expected %0d", prog_data, e);
          end
        end
      end
      cfg_valid = (sent < T) && (!gapped || (cyc % 2 == 0));
      cfg_data = sent + 1;
      #1;
      if (sent == T) begin
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
          n_err++; $display("FAIL load_ready_drop: got %b expected 0", cfg_ready);
        end
      end else if (!gapped) begin
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_err++; $display("FAIL load_ready_high: got %b expected 1 (word %0d)", cfg_ready, sent + 1);
        end
      end
      acc = cfg_valid && cfg_ready;
      if (acc) begin
        exp_q.push_back(cfg_data);
        sent++;
      end
      prev_acc = acc;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (sent != T || shifts != T) begin
      n_err++; $display("FAIL load_counts: got accepts=%0d shifts=%0d expected %0d %0d", sent, shifts, T, T);
    end
    n_cmp++;
    if (done !== 1'b1 || fabric_nres !== 1'b1 || prog_shft !== 1'b0) begin
      n_err++;
      $display("FAIL load_done: got done=%b nres=%b shft=%b expected 1 1 0", done, fabric_nres, prog_shft);
    end
    n_cmp++;
    if (word_cnt !== 7'(T)) begin
      n_err++; $display("FAIL load_word_cnt: got %0d expected %0d", word_cnt, T);
    end
    n_cmp++;
    if (chain_i !== 32'd1) begin
      n_err++; $display("FAIL load_chain_tail: got %0d expected 1", chain_i);
    end
  endtask

  task automatic test_verify(input bit stuck);
    bit ok, bad;
    logic [31:0] e;
    exp_q.delete();
    next_word = 1;
    stuck_en = stuck;
    pulse_start(1'b1);
    feed(T, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL verify_feed: got timeout expected %0d accepts", T);
    end
    n_cmp++;
    if (prog_shft !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL verify_last_load_shift: got shft=%b busy=%b expected 1 1", prog_shft, busy);
    end
    @(negedge clk);
    for (int k = 0; k < T; k++) begin
      n_cmp++;
      if (prog_shft !== 1'b1) begin
        n_err++; $display("FAIL verify_shft: got %b expected 1 (cycle %0d)", prog_shft, k);
      end
      n_cmp++;
      if (prog_data !== chain_i) begin
        n_err++; $display("FAIL verify_loopback: got %0d expected %0d", prog_data, chain_i);
      end
      if (!stuck && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (chain_i !== e) begin
          n_err++; $display("FAIL verify_chain_seq: got %0d expected %0d", chain_i, e);
        end
      end
      @(negedge clk);
    end
    exp_q.delete();
    if (!stuck) begin
      n_cmp++;
      if (done !== 1'b1 || err !== 1'b0 || fabric_nres !== 1'b1 || prog_shft !== 1'b0) begin
        n_err++;
        $display("FAIL verify_done: got done=%b err=%b nres=%b shft=%b expected 1 0 1 0",
                 done, err, fabric_nres, prog_shft);
      end
      n_cmp++;
      if (word_cnt !== 7'(T)) begin
        n_err++; $display("FAIL verify_word_cnt: got %0d expected %0d", word_cnt, T);
      end
      bad = 1'b0;
      for (int i = 0; i < T; i++) if (chain[i] !== 32'(T - i)) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_err++; $display("FAIL verify_chain_restored: got tail=%0d head=%0d expected 1 %0d", chain[T-1], chain[0], T);
      end
    end else begin
      repeat (3) begin
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0 || fabric_nres !== 1'b0 || prog_shft !== 1'b0) begin
          n_err++;
          $display("FAIL verify_error: got err=%b done=%b nres=%b shft=%b expected 1 0 0 0",
                   err, done, fabric_nres, prog_shft);
        end
        @(negedge clk);
      end
      stuck_en = 1'b0;
      pulse_start(1'b0);
      n_cmp++;
      if (busy !== 1'b1 || word_cnt !== 7'd0 || err !== 1'b0) begin
        n_err++;
        $display("FAIL error_restart: got busy=%b cnt=%0d err=%b expected 1 0 0", busy, word_cnt, err);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    exp_q.delete();
    next_word = 1;
    pulse_start(1'b0);
    feed(20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL abort_feed: got timeout expected 20 accepts");
    end
    cfg_valid = 1'b1;
    cfg_data = 32'd21;
    abort = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL abort_ready: got %b expected 0", cfg_ready);
    end
    @(negedge clk);
    abort = 1'b0;
    cfg_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || prog_shft !== 1'b0 ||
        cfg_ready !== 1'b0 || fabric_nres !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b done=%b err=%b shft=%b ready=%b nres=%b expected all 0",
               busy, done, err, prog_shft, cfg_ready, fabric_nres);
    end
    n_cmp++;
    if (word_cnt !== 7'd20) begin
      n_err++; $display("FAIL abort_word_cnt: got %0d expected 20", word_cnt);
    end
  endtask

  task automatic test_reset_verify();
    bit ok;
    exp_q.delete();
    next_word = 1;
    pulse_start(1'b1);
    feed(T, ok);
    exp_q.delete();
    repeat (30) @(negedge clk);
    n_cmp++;
    if (!ok || busy !== 1'b1 || prog_shft !== 1'b1) begin
      n_err++; $display("FAIL mid_verify: got ok=%b busy=%b shft=%b expected 1 1 1", ok, busy, prog_shft);
    end
    res = 1'b1;
    #1;
    n_cmp++;
    if ({prog_shft, cfg_ready, fabric_nres, busy, done, err} !== 6'b0 || word_cnt !== 7'd0 ||
        prog_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_in_verify: got flags=%b cnt=%0d data=%0d expected 000000 0 0",
               {prog_shft, cfg_ready, fabric_nres, busy, done, err}, word_cnt, prog_data);
    end
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit ok;
    exp_q.delete();
    next_word = 1;
    pulse_start(1'b0);
    feed(10, ok);
    start = 1'b1;
    verify_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    verify_en = 1'b0;
    n_cmp++;
    if (!ok || word_cnt !== 7'd10 || busy !== 1'b1) begin
      n_err++; $display("FAIL start_in_load: got ok=%b cnt=%0d busy=%b expected 1 10 1", ok, word_cnt, busy);
    end
    feed(T - 10, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || done !== 1'b1 || word_cnt !== 7'(T)) begin
      n_err++; $display("FAIL start_load_done: got ok=%b done=%b cnt=%0d expected 1 1 %0d", ok, done, word_cnt, T);
    end
    pulse_start(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || fabric_nres !== 1'b0 || word_cnt !== 7'd0) begin
      n_err++;
      $display("FAIL start_in_done: got busy=%b done=%b nres=%b cnt=%0d expected 1 0 0 0",
               busy, done, fabric_nres, word_cnt);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_verify(1'b0);
    test_verify(1'b1);
    test_abort();
    test_reset_verify();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
